// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl_if.sv
// Pop handshake between the CSB-master FIFO read controller and its consumer.
// The controller drives the master side; the consumer drives the slave side.
interface nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl_if #(
    parameter int DW = 50
);
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;

    modport master (output rd_pvld, output rd_pd, input rd_prdy);
    modport slave  (input rd_pvld, input rd_pd, output rd_prdy);
endinterface

// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl.sv
// Read-side gray pointer control for the CSB-master async FIFO (read clock domain only).
// Define NV_NVDLA_CSB_FIFO_RD_OUT_FLOP_EN to register the pop outputs behind a one-entry stage.
module nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl #(
    parameter int AW = 2,
    parameter int DW = 50
) (
    input  logic          rd_clk,
    input  logic          rd_reset,
    input  logic [AW:0]   wr_ptr_gray,
    output logic [AW:0]   rd_ptr_gray,
    output logic [AW-1:0] rd_adr,
    input  logic [DW-1:0] rd_ram_data,
    output logic [AW:0]   rd_count,
    nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl_if.master pop_if
);

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [AW:0] wr_sync0_r;
    logic [AW:0] wr_sync1_r;
    logic [AW:0] rd_gray_r;
    logic [AW:0] wr_bin_s;
    logic [AW:0] rd_bin_s;
    logic [AW:0] rd_gray_next_s;
    logic        empty_s;
    logic        adv_s;

    // Two-flop synchronizer for the asynchronous write pointer
    always_ff @(posedge rd_clk) begin
        if (rd_reset) begin
            wr_sync0_r <= {(AW+1){1'b0}};
            wr_sync1_r <= {(AW+1){1'b0}};
        end else begin
            wr_sync0_r <= wr_ptr_gray;
            wr_sync1_r <= wr_sync0_r;
        end
    end

    // Pointer decode, empty detect and next read pointer
    always_comb begin
        wr_bin_s       = gray2bin(wr_sync1_r);
        rd_bin_s       = gray2bin(rd_gray_r);
        rd_gray_next_s = bin2gray(rd_bin_s + {{AW{1'b0}}, 1'b1});
        empty_s        = (wr_sync1_r == rd_gray_r);
    end

    // Read pointer kept in gray so the write domain can sample it safely
    always_ff @(posedge rd_clk) begin
        if (rd_reset) begin
            rd_gray_r <= {(AW+1){1'b0}};
        end else if (adv_s) begin
            rd_gray_r <= rd_gray_next_s;
        end else begin
            rd_gray_r <= rd_gray_r;
        end
    end

`ifdef NV_NVDLA_CSB_FIFO_RD_OUT_FLOP_EN
    logic          out_vld_r;
    logic [DW-1:0] out_pd_r;

    // Refill the output stage whenever it is free or draining this cycle
    always_comb begin
        adv_s = (!out_vld_r || pop_if.rd_prdy) && !empty_s;
    end

    // One-entry output register; the RAM pointer advances on load, not on pop
    always_ff @(posedge rd_clk) begin
        if (rd_reset) begin
            out_vld_r <= 1'b0;
            out_pd_r  <= {DW{1'b0}};
        end else if (adv_s) begin
            out_vld_r <= 1'b1;
            out_pd_r  <= rd_ram_data;
        end else if (pop_if.rd_prdy) begin
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= out_vld_r;
        end
    end

    assign pop_if.rd_pvld = out_vld_r;
    assign pop_if.rd_pd   = out_pd_r;
`else
    // Pop straight from the RAM read port
    always_comb begin
        adv_s = !empty_s && pop_if.rd_prdy;
    end

    assign pop_if.rd_pvld = !empty_s;
    assign pop_if.rd_pd   = rd_ram_data;
`endif

    assign rd_ptr_gray = rd_gray_r;
    assign rd_adr      = rd_bin_s[AW-1:0];
    assign rd_count    = wr_bin_s - rd_bin_s;

endmodule

// File: tb/tb_nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl.sv
// Scoreboard bench for the FIFO read controller: a write-side model fills a RAM
// array and a monitor checks pops, pointers and occupancy against entry counts.
module tb_nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl;
    localparam int AW = 2;
    localparam int DW = 50;
`ifdef NV_NVDLA_CSB_FIFO_RD_OUT_FLOP_EN
    localparam int LAT = 3;
    localparam int OREG = 1;
`else
    localparam int LAT = 2;
    localparam int OREG = 0;
`endif

    logic          rd_clk = 1'b0;
    logic          rd_reset;
    logic [AW:0]   wr_ptr_gray;
    logic [AW:0]   rd_ptr_gray;
    logic [AW-1:0] rd_adr;
    logic [DW-1:0] rd_ram_data;
    logic [AW:0]   rd_count;
    logic [DW-1:0] mem [4];

    nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl_if #(.DW(DW)) pop_if ();

    nv_nvdla_csb_master_falcon2csb_fifo_rd_ctrl #(.AW(AW), .DW(DW)) dut (
        .rd_clk      (rd_clk),
        .rd_reset    (rd_reset),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .rd_adr      (rd_adr),
        .rd_ram_data (rd_ram_data),
        .rd_count    (rd_count),
        .pop_if      (pop_if)
    );

    assign rd_ram_data = mem[rd_adr];
    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;   // entries written since reset
    int pop_total = 0;  // entries popped since reset
    int h1 = 0;         // wr_total as of one edge ago
    int h2 = 0;         // wr_total as visible after the synchronizer
    logic [DW-1:0] exp_q[$];
    bit            hold_r = 1'b0;
    logic [DW-1:0] hold_d;
    logic [AW:0]   prev_ptr = '0;

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Delay line modelling the two-edge visibility of written entries
    always @(posedge rd_clk) begin
        if (rd_reset) begin
            h1 <= 0;
            h2 <= 0;
        end else begin
            h1 <= wr_total;
            h2 <= h1;
        end
    end

    // Monitor: compare outputs against entry counts and pop the scoreboard
    always @(negedge rd_clk) begin
        int loaded;
        if (rd_reset) begin
            pop_total = 0;
            hold_r    = 1'b0;
            prev_ptr  = '0;
        end else begin
`ifdef NV_NVDLA_CSB_FIFO_RD_OUT_FLOP_EN
            loaded = pop_total + (pop_if.rd_pvld ? 1 : 0);
`else
            loaded = pop_total;
            check("rd_pvld", pop_if.rd_pvld, h2 != pop_total);
`endif
            check("rd_count", rd_count, h2 - loaded);
            check("count_bound", rd_count <= 3'd4, 1);
            check("rd_ptr_gray", rd_ptr_gray, to_gray(loaded));
            check("rd_adr", rd_adr, loaded % 4);
            if (rd_ptr_gray != prev_ptr)
                check("gray_one_bit", $countones(rd_ptr_gray ^ prev_ptr), 1);
            prev_ptr = rd_ptr_gray;
            if (pop_if.rd_pvld) begin
                if (hold_r) check("pd_stable", pop_if.rd_pd, hold_d);
                if (pop_if.rd_prdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop: got %0h expected none", pop_if.rd_pd);
                    end else begin
                        check("rd_pd", pop_if.rd_pd, exp_q.pop_front());
                    end
                    pop_total++;
                end
            end
            hold_r = pop_if.rd_pvld && !pop_if.rd_prdy;
            hold_d = pop_if.rd_pd;
        end
    end

    task automatic step(input bit do_wr, input bit prdy);
        logic [DW-1:0] d;
        @(posedge rd_clk);
        #1;
        pop_if.rd_prdy = prdy;
        if (do_wr && (wr_total - pop_total) < 4) begin
            d = DW'({$urandom(), $urandom()});
            mem[wr_total % 4] = d;
            exp_q.push_back(d);
            wr_total++;
            wr_ptr_gray = to_gray(wr_total);
        end
    endtask

    task automatic wait_pvld(input string name, input int lat);
        int n;
        n = 0;
        while (n < 10 && !pop_if.rd_pvld) begin
            @(posedge rd_clk);
            @(negedge rd_clk);
            n++;
        end
        check(name, n, lat);
    endtask

    initial begin
        rd_reset       = 1'b1;
        pop_if.rd_prdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem[i] = DW'({$urandom(), $urandom()});
            exp_q.push_back(mem[i]);
        end
        mem[3]      = '0;
        wr_total    = 3;
        wr_ptr_gray = to_gray(3);

        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        check("reset_pvld", pop_if.rd_pvld, 0);
        check("reset_count", rd_count, 0);
        check("reset_ptr", rd_ptr_gray, 0);
        check("reset_adr", rd_adr, 0);
`ifdef NV_NVDLA_CSB_FIFO_RD_OUT_FLOP_EN
        check("reset_pd", pop_if.rd_pd, 0);
`endif
        @(posedge rd_clk);
        #1;
        rd_reset = 1'b0;
        wait_pvld("release_latency", LAT);

        repeat (5) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        step(1'b1, 1'b0);
        wait_pvld("single_latency", LAT);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        @(negedge rd_clk);
        check("single_popped_pvld", pop_if.rd_pvld, 0);

        repeat (4) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        @(negedge rd_clk);
        check("fill_count", rd_count, 4 - OREG);
        repeat (6) step(1'b0, 1'b1);

        repeat (400) step($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1);

        repeat (8) step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        @(posedge rd_clk);
        #1;
        rd_reset = 1'b1;
        exp_q.delete();
        wr_total    = 0;
        wr_ptr_gray = '0;
        @(posedge rd_clk);
        #1;
        rd_reset = 1'b0;
        @(negedge rd_clk);
        check("midreset_ptr", rd_ptr_gray, 0);
        check("midreset_pvld", pop_if.rd_pvld, 0);

        repeat (150) step($urandom_range(0, 99) < 50, $urandom_range(0, 3) != 0);
        repeat (10) step(1'b0, 1'b1);
        check("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
